// File: rtl/imem_sequencer.sv
// Load/run sequencer for one PE's BRAM instruction memory: streams a program in,
// replays it iter_num times and flags read data aligned to the BRAM latency.
module imem_sequencer #(
  parameter int INST_WIDTH    = 36,
  parameter int IM_ADDR_WIDTH = 8,
  parameter int ITER_WIDTH    = 8,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_in_v,
  input  logic [INST_WIDTH-1:0]    inst_in,
  input  logic                     start,
  input  logic [ITER_WIDTH-1:0]    iter_num,
  input  logic                     stall,
  output logic                     imem_we,
  output logic [IM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [INST_WIDTH-1:0]    imem_wdata,
  output logic                     imem_re,
  output logic [IM_ADDR_WIDTH-1:0] imem_raddr,
  output logic                     inst_out_v,
  output logic [IM_ADDR_WIDTH:0]   prog_len,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);
  localparam int DEPTH = 2**IM_ADDR_WIDTH;
  localparam int DW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [IM_ADDR_WIDTH:0]   wcnt, wcnt_nx, prog_len_nx;
  logic [IM_ADDR_WIDTH-1:0] pc, pc_nx;
  logic [ITER_WIDTH-1:0]    iter, iter_nx, iter_max, iter_max_nx;
  logic [DW-1:0]            dcnt, dcnt_nx;
  logic                     ovf_nx, done_q, done_q_nx;
  logic [RD_LATENCY:1]      vld_pipe;
  logic                     full, last_pc, last_iter, drain_end;

  assign full      = (wcnt == (IM_ADDR_WIDTH+1)'(DEPTH));
  assign last_pc   = ({1'b0, pc} == prog_len - 1'b1);
  assign last_iter = (iter == iter_max - 1'b1);
  // No reads are issued in DRAIN, so the final valid lands on its last cycle.
  assign drain_end = (state == DRAIN) && (dcnt == DW'(RD_LATENCY-1));

  assign imem_wdata = inst_in;
  assign imem_raddr = pc;
  assign inst_out_v = vld_pipe[RD_LATENCY];
  assign busy       = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign done       = done_q | drain_end;

  always_comb begin
    state_nx    = state;
    wcnt_nx     = wcnt;
    prog_len_nx = prog_len;
    pc_nx       = pc;
    iter_nx     = iter;
    iter_max_nx = iter_max;
    dcnt_nx     = dcnt;
    ovf_nx      = ovf;
    done_q_nx   = 1'b0;
    imem_we     = 1'b0;
    imem_waddr  = '0;
    imem_re     = 1'b0;
    case (state)
      IDLE, READY: begin
        if (inst_in_v) begin
          imem_we  = 1'b1;
          wcnt_nx  = (IM_ADDR_WIDTH+1)'(1);
          ovf_nx   = 1'b0;
          state_nx = LOAD;
        end else if (start && state == READY) begin
          if (iter_num == '0) begin
            done_q_nx = 1'b1;
          end else begin
            iter_max_nx = iter_num;
            pc_nx       = '0;
            iter_nx     = '0;
            state_nx    = RUN;
          end
        end
      end
      LOAD: begin
        if (inst_in_v) begin
          if (!full) begin
            imem_we    = 1'b1;
            imem_waddr = wcnt[IM_ADDR_WIDTH-1:0];
            wcnt_nx    = wcnt + 1'b1;
          end else begin
            ovf_nx = 1'b1;
          end
        end else begin
          prog_len_nx = wcnt;
          state_nx    = READY;
        end
      end
      RUN: begin
        imem_re = ~stall;
        if (!stall) begin
          if (last_pc) begin
            pc_nx   = '0;
            iter_nx = iter + 1'b1;
            if (last_iter) begin
              dcnt_nx  = '0;
              state_nx = DRAIN;
            end
          end else begin
            pc_nx = pc + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_end) state_nx = READY;
        else           dcnt_nx  = dcnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      prog_len <= '0;
      pc       <= '0;
      iter     <= '0;
      iter_max <= '0;
      dcnt     <= '0;
      ovf      <= 1'b0;
      done_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      prog_len <= prog_len_nx;
      pc       <= pc_nx;
      iter     <= iter_nx;
      iter_max <= iter_max_nx;
      dcnt     <= dcnt_nx;
      ovf      <= ovf_nx;
      done_q   <= done_q_nx;
      vld_pipe[1] <= imem_re;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end
endmodule
